mnist_image_writer: RTL and testbench

Producer-side driver for the classifier's pixel write port. Accepts a raw 8-bit grayscale image as a valid/ready byte stream and binarizes each pixel against a threshold. Issues one registered write per pixel (enable, address, data) into the classifier image memory, then waits a fixed settle time. It captures the classifier's digit output and hands it upstream through a valid/ready result handshake.

---
 rtl/mnist_image_writer.sv | 145 ++++++++++++++
 tb/tb_mnist_image_writer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mnist_image_writer.sv
`default_nettype none
// ============================================================================
// Module   : mnist_image_writer
// Purpose  : Binarizes a streamed 8-bit image into the classifier image memory
//            and returns the classifier's digit through a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module mnist_image_writer #(
  parameter int NUM_PIXELS    = 784,
  parameter int ADDR_W        = 10,
  parameter int THRESHOLD     = 128,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic [7:0]        write_data,
  input  logic [3:0]        digit_in,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [3:0]        result_digit,
  output logic [ADDR_W-1:0] result_ones,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam int                  c_SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [ADDR_W-1:0]   c_LAST_PIX = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [ADDR_W-1:0]   c_ONES_MAX = {ADDR_W{1'b1}};
  localparam logic [c_SET_W-1:0]  c_SET_INIT = c_SET_W'(SETTLE_CYCLES - 1);
  localparam logic [7:0]          c_THRESH   = 8'(THRESHOLD);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pix_cnt;
  logic [ADDR_W-1:0]   r_ones_cnt;
  logic [c_SET_W-1:0]  r_settle_cnt;
  logic                r_s_ready;
  logic                r_write_enable;
  logic [ADDR_W-1:0]   r_write_addr;
  logic [7:0]          r_write_data;
  logic                r_result_valid;
  logic [3:0]          r_result_digit;
  logic [ADDR_W-1:0]   r_result_ones;

  logic                w_accept;
  logic                w_bit;

  assign w_accept = s_valid & r_s_ready;
  assign w_bit    = (s_data >= c_THRESH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_pix_cnt      <= '0;
      r_ones_cnt     <= '0;
      r_settle_cnt   <= '0;
      r_s_ready      <= 1'b0;
      r_write_enable <= 1'b0;
      r_write_addr   <= '0;
      r_write_data   <= '0;
      r_result_valid <= 1'b0;
      r_result_digit <= '0;
      r_result_ones  <= '0;
    end else begin
      r_write_enable <= 1'b0;
      case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_state    <= LOAD;
            r_s_ready  <= 1'b1;
            r_pix_cnt  <= '0;
            r_ones_cnt <= '0;
          end
        end

        LOAD: begin
          // A restart wins over a byte accepted in the same cycle
          if (frame_start) begin
            r_pix_cnt  <= '0;
            r_ones_cnt <= '0;
          end else if (w_accept) begin
            r_write_enable <= 1'b1;
            r_write_addr   <= r_pix_cnt;
            r_write_data   <= {7'b0, w_bit};
            r_pix_cnt      <= r_pix_cnt + 1'b1;
            if (w_bit && (r_ones_cnt != c_ONES_MAX))
              r_ones_cnt <= r_ones_cnt + 1'b1;
            if (r_pix_cnt == c_LAST_PIX) begin
              r_state      <= SETTLE;
              r_s_ready    <= 1'b0;
              r_settle_cnt <= c_SET_INIT;
            end
          end
        end

        SETTLE: begin
          if (r_settle_cnt == '0) begin
            r_result_digit <= digit_in;
            r_result_ones  <= r_ones_cnt;
            r_state        <= REPORT;
          end else begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
          end
        end

        REPORT: begin
          // Valid rises one edge after the capture; data is already stable
          if (!r_result_valid) begin
            r_result_valid <= 1'b1;
          end else if (result_ready) begin
            r_result_valid <= 1'b0;
            r_state        <= IDLE;
          end
        end

        default: begin
          r_state   <= IDLE;
          r_s_ready <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready      = r_s_ready;
  assign write_enable = r_write_enable;
  assign write_addr   = r_write_addr;
  assign write_data   = r_write_data;
  assign result_valid = r_result_valid;
  assign result_digit = r_result_digit;
  assign result_ones  = r_result_ones;
  assign busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mnist_image_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mnist_image_writer
// Purpose  : Directed self-checking bench for mnist_image_writer.
// Revision : 1.0
// ============================================================================
module tb_mnist_image_writer;

  localparam int NUM_PIXELS    = 784;
  localparam int ADDR_W        = 10;
  localparam int SETTLE_CYCLES = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start;
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [7:0]        write_data;
  logic [3:0]        digit_in;
  logic              result_valid;
  logic              result_ready;
  logic [3:0]        result_digit;
  logic [ADDR_W-1:0] result_ones;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  int exp_addr = 0;
  int exp_ones = 0;
  int wr_seen  = 0;
  int n;
  int k;

  always #5 clk = ~clk;

  mnist_image_writer #(
    .NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W), .THRESHOLD(128), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .digit_in(digit_in), .result_valid(result_valid), .result_ready(result_ready),
    .result_digit(result_digit), .result_ones(result_ones), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, then check the write port
  task automatic cycle(input logic v, input logic [7:0] d, input logic fs, input logic rr);
    logic acc, restart, b;
    s_valid      = v;
    s_data       = d;
    frame_start  = fs;
    result_ready = rr;
    acc     = v && s_ready;
    restart = fs && (s_ready || !busy);
    b       = (d >= 8'd128);
    @(posedge clk); #1;
    if (acc && !fs) begin
      check("wr_en", 32'(write_enable), 32'd1);
      check("wr_addr", 32'(write_addr), 32'(exp_addr));
      check("wr_data", 32'(write_data), 32'({7'b0, b}));
      exp_addr++;
      if (b) exp_ones++;
    end else begin
      check("wr_quiet", 32'(write_enable), 32'd0);
    end
    if (write_enable) wr_seen++;
    if (restart) begin
      exp_addr = 0;
      exp_ones = 0;
    end
  endtask

  task automatic wait_result(input logic v, input logic fs, input logic rr, output int cnt);
    cnt = 0;
    while (!result_valid && cnt < 20) begin
      cycle(v, 8'hFF, fs, rr);
      if (v) check("s_ready_low_post_load", 32'(s_ready), 32'd0);
      cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; s_valid = 1'b0; s_data = '0;
    digit_in = 4'd0; result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_wr_en", 32'(write_enable), 32'd0);
    check("rst_wr_addr", 32'(write_addr), 32'd0);
    check("rst_wr_data", 32'(write_data), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_digit", 32'(result_digit), 32'd0);
    check("rst_ones", 32'(result_ones), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of a frame
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) cycle(1'b1, 8'd200, 1'b0, 1'b0);
    rst_n = 1'b0; s_valid = 1'b1; frame_start = 1'b0;
    @(posedge clk); #1;
    check("midrst_wr_en", 32'(write_enable), 32'd0);
    check("midrst_wr_addr", 32'(write_addr), 32'd0);
    check("midrst_wr_data", 32'(write_data), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    exp_addr = 0; exp_ones = 0;
    cycle(1'b1, 8'd200, 1'b0, 1'b0);
    check("idle_no_ready", 32'(s_ready), 32'd0);

    // Frame 1: alternating 127/128, continuous valid
    digit_in = 4'd7;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("f1_s_ready_rise", 32'(s_ready), 32'd1);
    check("f1_busy", 32'(busy), 32'd1);
    wr_seen = 0;
    for (int i = 0; i < NUM_PIXELS; i++) cycle(1'b1, (i % 2 == 1) ? 8'd128 : 8'd127, 1'b0, 1'b0);
    check("f1_s_ready_drop", 32'(s_ready), 32'd0);
    check("f1_last_addr", 32'(write_addr), 32'd783);
    wait_result(1'b0, 1'b0, 1'b0, n);
    check("f1_latency", 32'(n), 32'(SETTLE_CYCLES + 1));
    check("f1_writes", 32'(wr_seen), 32'd784);
    check("f1_digit", 32'(result_digit), 32'd7);
    check("f1_ones", 32'(result_ones), 32'd392);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("f1_valid_fall", 32'(result_valid), 32'd0);
    check("f1_busy_fall", 32'(busy), 32'd0);

    // Frame 2: random valid, stalled result
    digit_in = 4'd5;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    wr_seen = 0;
    k = 0;
    while (exp_addr < NUM_PIXELS && k < 5000) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
      k++;
    end
    check("f2_all_accepted", 32'(exp_addr), 32'd784);
    wait_result(1'b0, 1'b0, 1'b0, n);
    check("f2_latency", 32'(n), 32'(SETTLE_CYCLES + 1));
    check("f2_writes", 32'(wr_seen), 32'd784);
    digit_in = 4'd9;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      check("f2_hold_valid", 32'(result_valid), 32'd1);
      check("f2_hold_digit", 32'(result_digit), 32'd5);
      check("f2_hold_ones", 32'(result_ones), 32'(exp_ones));
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("f2_valid_fall", 32'(result_valid), 32'd0);

    // Frame 3: restart after 300 bytes, result_ready held high
    digit_in = 4'd2;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    check("f3_restart_no_write", 32'(write_enable), 32'd0);
    check("f3_restart_ready", 32'(s_ready), 32'd1);
    for (int i = 0; i < NUM_PIXELS; i++) cycle(1'b1, (i % 4 == 0) ? 8'd200 : 8'd50, 1'b0, 1'b1);
    wait_result(1'b0, 1'b0, 1'b1, n);
    check("f3_latency", 32'(n), 32'(SETTLE_CYCLES + 1));
    check("f3_digit", 32'(result_digit), 32'd2);
    check("f3_ones", 32'(result_ones), 32'd196);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("f3_pulse", 32'(result_valid), 32'd0);
    check("f3_idle", 32'(busy), 32'd0);

    // Frame 4: all 0xFF; valid and frame_start held during SETTLE/REPORT
    digit_in = 4'hC;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    wr_seen = 0;
    for (int i = 0; i < NUM_PIXELS; i++) cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    wait_result(1'b1, 1'b1, 1'b0, n);
    check("f4_latency", 32'(n), 32'(SETTLE_CYCLES + 1));
    check("f4_ones", 32'(result_ones), 32'd784);
    check("f4_digit", 32'(result_digit), 32'hC);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'hFF, 1'b1, 1'b0);
      check("f4_report_busy", 32'(busy), 32'd1);
      check("f4_report_valid", 32'(result_valid), 32'd1);
      check("f4_report_ready", 32'(s_ready), 32'd0);
    end
    check("f4_writes", 32'(wr_seen), 32'd784);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("f4_idle", 32'(busy), 32'd0);
    cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    check("f4_new_frame", 32'(s_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
